lsu_mem_if: RTL and testbench

Load/store initiator in the MEM stage that issues byte, half and word accesses to the data-RAM wrapper and returns formatted load data to writeback. The block accepts one request at a time from EX/MEM over a valid/ready handshake. It checks alignment, drives the RAM's `mem_op`, `wen`, `ren`, `addr` and write-data for the required cycles, then captures the read result and holds the response until writeback takes it. It is the requester counterpart of the data RAM's responder port.

---
 rtl/lsu_mem_if_pkg.sv | 23 ++
 rtl/lsu_mem_if_align_chk.sv | 42 ++++
 rtl/lsu_mem_if.sv | 168 ++++++++++++++++
 tb/tb_lsu_mem_if.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_if_pkg.sv
// lsu_mem_if_pkg: mem_op codes shared with the data RAM wrapper and the
// request bundle latched by the MEM-stage load/store initiator.
package lsu_mem_if_pkg;

    localparam logic [2:0] LB_TYPE  = 3'd0;
    localparam logic [2:0] LH_TYPE  = 3'd1;
    localparam logic [2:0] LW_TYPE  = 3'd2;
    localparam logic [2:0] LBU_TYPE = 3'd3;
    localparam logic [2:0] LHU_TYPE = 3'd4;
    localparam logic [2:0] SB_TYPE  = 3'd5;
    localparam logic [2:0] SH_TYPE  = 3'd6;
    localparam logic [2:0] SW_TYPE  = 3'd7;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        is_load;
        logic        err;
    } lsu_req_t;

endpackage

// File: rtl/lsu_mem_if_align_chk.sv
// lsu_align_chk: combinational op / address legality check.
// In: mem_op, addr_lo (addr[1:0]). Out: err, is_load.
module lsu_align_chk
    import lsu_mem_if_pkg::*;
(
    input  logic [2:0] mem_op,
    input  logic [1:0] addr_lo,
    output logic       err,
    output logic       is_load
);

    always_comb begin
        err     = 1'b0;
        is_load = 1'b0;
        unique case (1'b1)
            (mem_op == LB_TYPE) || (mem_op == LBU_TYPE): begin
                is_load = 1'b1;
            end
            (mem_op == LH_TYPE) || (mem_op == LHU_TYPE): begin
                is_load = 1'b1;
                err     = addr_lo[0];
            end
            (mem_op == LW_TYPE): begin
                is_load = 1'b1;
                err     = |addr_lo;
            end
            (mem_op == SB_TYPE): begin
                err = 1'b0;
            end
            (mem_op == SH_TYPE): begin
                err = addr_lo[0];
            end
            (mem_op == SW_TYPE): begin
                err = |addr_lo;
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: MEM-stage load/store initiator towards the data RAM.
// Ports: req_* (EX/MEM handshake), rsp_* (to writeback), flush, dram_*.
module lsu_mem_if
    import lsu_mem_if_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_mem_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_rd,
    output logic        rsp_is_load,
    output logic        rsp_err,
    input  logic        flush,
    output logic [2:0]  dram_mem_op,
    output logic        dram_wen,
    output logic        dram_ren,
    output logic [31:0] dram_addr,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

    state_t     state_q;
    state_t     state_d;
    lsu_req_t   req_q;
    logic [31:0] rdata_q;
    logic [1:0] cnt_q;
    logic       ready_en_q;
    logic       chk_err;
    logic       chk_is_load;
    logic       accept;

    lsu_align_chk u_chk (
        .mem_op  (req_mem_op),
        .addr_lo (req_addr[1:0]),
        .err     (chk_err),
        .is_load (chk_is_load)
    );

    assign accept = req_valid & req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = chk_err ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // a flushed store still writes this cycle; only the
                // response is dropped
                if (flush) begin
                    state_d = S_IDLE;
                end else if (req_q.is_load) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (flush || rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready   = ready_en_q & (state_q == S_IDLE) & ~flush;
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        rsp_rd      = '0;
        rsp_is_load = 1'b0;
        rsp_err     = 1'b0;
        dram_mem_op = '0;
        dram_wen    = 1'b0;
        dram_ren    = 1'b0;
        dram_addr   = '0;
        dram_wdata  = '0;
        unique case (state_q)
            S_ISSUE: begin
                dram_mem_op = req_q.op;
                dram_addr   = req_q.addr;
                dram_ren    = req_q.is_load;
                dram_wen    = ~req_q.is_load;
                dram_wdata  = req_q.is_load ? '0 : req_q.wdata;
            end
            S_WAIT: begin
                dram_mem_op = req_q.op;
                dram_addr   = req_q.addr;
                dram_ren    = 1'b1;
            end
            S_RESP: begin
                rsp_valid   = 1'b1;
                rsp_rdata   = rdata_q;
                rsp_rd      = req_q.rd;
                rsp_is_load = req_q.is_load;
                rsp_err     = req_q.err;
            end
            default: begin
            end
        endcase
    end

    // ready_en_q keeps req_ready low until the first edge out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (accept) begin
                req_q.op      <= req_mem_op;
                req_q.addr    <= req_addr;
                req_q.wdata   <= req_wdata;
                req_q.rd      <= req_rd;
                req_q.is_load <= chk_is_load;
                req_q.err     <= chk_err;
                rdata_q       <= '0;
                cnt_q         <= '0;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + 2'd1;
                if ((cnt_q == CNT_LAST) && !flush) begin
                    rdata_q <= dram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed bench for lsu_mem_if with RD_LAT=1 and RD_LAT=3
// instances, each backed by a byte-array data RAM model.
module tb_lsu_mem_if;
    import lsu_mem_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid[2];
    logic        req_ready[2];
    logic [2:0]  req_op[2];
    logic [31:0] req_addr[2];
    logic [31:0] req_wdata[2];
    logic [4:0]  req_rd[2];
    logic        rsp_valid[2];
    logic        rsp_ready[2];
    logic [31:0] rsp_rdata[2];
    logic [4:0]  rsp_rd[2];
    logic        rsp_is_load[2];
    logic        rsp_err[2];
    logic        flush[2];
    logic [2:0]  d_op[2];
    logic        d_wen[2];
    logic        d_ren[2];
    logic [31:0] d_addr[2];
    logic [31:0] d_wdata[2];
    logic [31:0] d_rdata[2] = '{32'hBAD0BAD0, 32'hBAD0BAD0};

    logic [7:0]  mem[2][1024];
    int          wcnt[2] = '{0, 0};
    int          rtot[2] = '{0, 0};
    int          rrun[2] = '{0, 0};
    logic        both_seen = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    lsu_mem_if #(.RD_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_mem_op(req_op[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_rd(req_rd[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_rd(rsp_rd[0]),
        .rsp_is_load(rsp_is_load[0]), .rsp_err(rsp_err[0]),
        .flush(flush[0]),
        .dram_mem_op(d_op[0]), .dram_wen(d_wen[0]),
        .dram_ren(d_ren[0]), .dram_addr(d_addr[0]),
        .dram_wdata(d_wdata[0]), .dram_rdata(d_rdata[0])
    );

    lsu_mem_if #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_mem_op(req_op[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_rd(req_rd[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_rd(rsp_rd[1]),
        .rsp_is_load(rsp_is_load[1]), .rsp_err(rsp_err[1]),
        .flush(flush[1]),
        .dram_mem_op(d_op[1]), .dram_wen(d_wen[1]),
        .dram_ren(d_ren[1]), .dram_addr(d_addr[1]),
        .dram_wdata(d_wdata[1]), .dram_rdata(d_rdata[1])
    );

    function automatic logic [31:0] fmt(input int k);
        logic [9:0] a;
        logic [7:0] b0, b1, b2, b3;
        a  = d_addr[k][9:0];
        b0 = mem[k][a];
        b1 = mem[k][a + 10'd1];
        b2 = mem[k][a + 10'd2];
        b3 = mem[k][a + 10'd3];
        case (d_op[k])
            LB_TYPE:  return {{24{b0[7]}}, b0};
            LBU_TYPE: return {24'd0, b0};
            LH_TYPE:  return {{16{b1[7]}}, b1, b0};
            LHU_TYPE: return {16'd0, b1, b0};
            LW_TYPE:  return {b3, b2, b1, b0};
            default:  return 32'd0;
        endcase
    endfunction

    // RAM model: data becomes valid RD_LAT edges after ren first rises
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (d_wen[k]) begin
                wcnt[k] <= wcnt[k] + 1;
                case (d_op[k])
                    SB_TYPE: begin
                        mem[k][d_addr[k][9:0]] <= d_wdata[k][7:0];
                    end
                    SH_TYPE: begin
                        mem[k][d_addr[k][9:0]] <= d_wdata[k][7:0];
                        mem[k][d_addr[k][9:0] + 10'd1] <= d_wdata[k][15:8];
                    end
                    SW_TYPE: begin
                        mem[k][d_addr[k][9:0]] <= d_wdata[k][7:0];
                        mem[k][d_addr[k][9:0] + 10'd1] <= d_wdata[k][15:8];
                        mem[k][d_addr[k][9:0] + 10'd2] <= d_wdata[k][23:16];
                        mem[k][d_addr[k][9:0] + 10'd3] <= d_wdata[k][31:24];
                    end
                    default: begin
                    end
                endcase
            end
            if (d_ren[k]) begin
                rtot[k] <= rtot[k] + 1;
                rrun[k] <= rrun[k] + 1;
                if (rrun[k] + 1 >= ((k == 0) ? 1 : 3)) begin
                    d_rdata[k] <= fmt(k);
                end else begin
                    d_rdata[k] <= 32'hBAD0BAD0;
                end
            end else begin
                rrun[k]    <= 0;
                d_rdata[k] <= 32'hBAD0BAD0;
            end
            if (d_wen[k] && d_ren[k]) begin
                both_seen <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send(input int k, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd);
        int n;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_op[k]    = op;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        req_rd[k]    = rd;
        n = 0;
        while (!req_ready[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[k]) begin
            chk("accept_timeout", {31'd0, req_ready[k]}, 32'd1);
            req_valid[k] = 1'b0;
        end else begin
            @(posedge clk);
            #1 req_valid[k] = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int k, output int lat);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[k]) break;
        end
        if (!rsp_valid[k]) begin
            chk("rsp_timeout", {31'd0, rsp_valid[k]}, 32'd1);
        end
    endtask

    task automatic ack(input int k);
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[k] = 1'b0;
    endtask

    task automatic txn(input int k, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, output int lat,
                       output logic [31:0] data, output logic err,
                       output logic isl, output logic [4:0] rdo,
                       output int wn, output int rn);
        int w0, r0;
        w0 = wcnt[k];
        r0 = rtot[k];
        send(k, op, addr, wd, rd);
        wait_rsp(k, lat);
        data = rsp_rdata[k];
        err  = rsp_err[k];
        isl  = rsp_is_load[k];
        rdo  = rsp_rd[k];
        ack(k);
        wn = wcnt[k] - w0;
        rn = rtot[k] - r0;
    endtask

    int          lat, wn, rn, w0;
    logic [31:0] d;
    logic        e, il, seen;
    logic [4:0]  r;

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_op[k]    = '0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            req_rd[k]    = '0;
            rsp_ready[k] = 1'b0;
            flush[k]     = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready[0]}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("rst_strobes", {30'd0, d_wen[0], d_ren[0]}, 32'd0);
        chk("rst_addr", d_addr[0], 32'd0);
        rst_n = 1'b1;
        #1 chk("ready_pre_edge", {31'd0, req_ready[0]}, 32'd0);
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready[0]}, 32'd1);

        txn(0, SW_TYPE, 32'h100, 32'hDEADBEEF, 5'd3, lat, d, e, il, r, wn, rn);
        chk("sw_lat", lat, 32'd2);
        chk("sw_wen_cycles", wn, 32'd1);
        chk("sw_ren_cycles", rn, 32'd0);
        chk("sw_err", {31'd0, e}, 32'd0);
        chk("sw_rdata", d, 32'd0);
        chk("sw_is_load", {31'd0, il}, 32'd0);

        txn(0, LW_TYPE, 32'h100, 32'd0, 5'd5, lat, d, e, il, r, wn, rn);
        chk("lw_lat", lat, 32'd3);
        chk("lw_rdata", d, 32'hDEADBEEF);
        chk("lw_is_load", {31'd0, il}, 32'd1);
        chk("lw_rd", {27'd0, r}, 32'd5);
        chk("lw_ren_cycles", rn, 32'd2);
        chk("lw_wen_cycles", wn, 32'd0);

        txn(0, SW_TYPE, 32'h100, 32'h80FF0000, 5'd0, lat, d, e, il, r, wn, rn);
        txn(0, LB_TYPE, 32'h103, 32'd0, 5'd7, lat, d, e, il, r, wn, rn);
        chk("lb_rdata", d, 32'hFFFFFF80);
        chk("lb_rd", {27'd0, r}, 32'd7);
        txn(0, LBU_TYPE, 32'h103, 32'd0, 5'd9, lat, d, e, il, r, wn, rn);
        chk("lbu_rdata", d, 32'h00000080);
        chk("lbu_rd", {27'd0, r}, 32'd9);
        txn(0, LH_TYPE, 32'h102, 32'd0, 5'd1, lat, d, e, il, r, wn, rn);
        chk("lh_rdata", d, 32'hFFFF80FF);
        txn(0, LHU_TYPE, 32'h102, 32'd0, 5'd1, lat, d, e, il, r, wn, rn);
        chk("lhu_rdata", d, 32'h000080FF);
        txn(0, SH_TYPE, 32'h104, 32'h1234ABCD, 5'd0, lat, d, e, il, r, wn, rn);
        txn(0, LH_TYPE, 32'h104, 32'd0, 5'd2, lat, d, e, il, r, wn, rn);
        chk("sh_lh_rdata", d, 32'hFFFFABCD);
        txn(0, SB_TYPE, 32'h107, 32'h0000015A, 5'd0, lat, d, e, il, r, wn, rn);
        txn(0, LBU_TYPE, 32'h107, 32'd0, 5'd2, lat, d, e, il, r, wn, rn);
        chk("sb_lbu_rdata", d, 32'h0000005A);
        txn(0, LW_TYPE, 32'h100, 32'd0, 5'd0, lat, d, e, il, r, wn, rn);
        chk("lw_rd0_rdata", d, 32'h80FF0000);
        chk("lw_rd0_lat", lat, 32'd3);

        txn(0, LH_TYPE, 32'h101, 32'd0, 5'd4, lat, d, e, il, r, wn, rn);
        chk("lh_mis_lat", lat, 32'd1);
        chk("lh_mis_err", {31'd0, e}, 32'd1);
        chk("lh_mis_rdata", d, 32'd0);
        chk("lh_mis_strobes", wn + rn, 32'd0);
        txn(0, SW_TYPE, 32'h102, 32'h11111111, 5'd0, lat, d, e, il, r, wn, rn);
        chk("sw_mis_lat", lat, 32'd1);
        chk("sw_mis_err", {31'd0, e}, 32'd1);
        chk("sw_mis_rdata", d, 32'd0);
        chk("sw_mis_strobes", wn + rn, 32'd0);

        send(0, LW_TYPE, 32'h100, 32'd0, 5'd6);
        wait_rsp(0, lat);
        chk("hold_lat", lat, 32'd3);
        req_valid[0] = 1'b1;
        req_op[0]    = SW_TYPE;
        req_addr[0]  = 32'h300;
        req_wdata[0] = 32'h0BADF00D;
        req_rd[0]    = 5'd0;
        w0 = wcnt[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, rsp_valid[0]}, 32'd1);
            chk("hold_rdata", rsp_rdata[0], 32'h80FF0000);
            chk("hold_rd", {27'd0, rsp_rd[0]}, 32'd6);
            chk("hold_ready", {31'd0, req_ready[0]}, 32'd0);
        end
        ack(0);
        @(negedge clk);
        chk("hold_next_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("hold_no_write", wcnt[0] - w0, 32'd0);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_rsp(0, lat);
        chk("after_hold_lat", lat, 32'd2);
        ack(0);
        txn(0, LW_TYPE, 32'h300, 32'd0, 5'd1, lat, d, e, il, r, wn, rn);
        chk("after_hold_rdata", d, 32'h0BADF00D);

        w0 = wcnt[0];
        send(0, SW_TYPE, 32'h180, 32'hCAFEF00D, 5'd0);
        @(negedge clk);
        chk("fs_wen", {31'd0, d_wen[0]}, 32'd1);
        flush[0] = 1'b1;
        @(posedge clk);
        #1 flush[0] = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | rsp_valid[0];
        end
        chk("fs_no_rsp", {31'd0, seen}, 32'd0);
        chk("fs_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("fs_wen_cycles", wcnt[0] - w0, 32'd1);
        txn(0, LW_TYPE, 32'h180, 32'd0, 5'd1, lat, d, e, il, r, wn, rn);
        chk("fs_mem", d, 32'hCAFEF00D);

        @(negedge clk);
        req_valid[0] = 1'b1;
        req_op[0]    = LW_TYPE;
        req_addr[0]  = 32'h100;
        flush[0]     = 1'b1;
        #1 chk("fi_ready_masked", {31'd0, req_ready[0]}, 32'd0);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        flush[0]     = 1'b0;
        @(negedge clk);
        chk("fi_no_ren", {31'd0, d_ren[0]}, 32'd0);
        chk("fi_ready", {31'd0, req_ready[0]}, 32'd1);

        send(0, LW_TYPE, 32'h100, 32'd0, 5'd4);
        wait_rsp(0, lat);
        flush[0] = 1'b1;
        @(posedge clk);
        #1 flush[0] = 1'b0;
        @(negedge clk);
        chk("fr_rsp_dropped", {31'd0, rsp_valid[0]}, 32'd0);
        chk("fr_ready", {31'd0, req_ready[0]}, 32'd1);

        txn(1, SW_TYPE, 32'h100, 32'h11223344, 5'd0, lat, d, e, il, r, wn, rn);
        chk("l3_sw_lat", lat, 32'd2);
        txn(1, LW_TYPE, 32'h100, 32'd0, 5'd8, lat, d, e, il, r, wn, rn);
        chk("l3_lw_lat", lat, 32'd5);
        chk("l3_lw_rdata", d, 32'h11223344);
        chk("l3_ren_cycles", rn, 32'd4);
        send(1, LW_TYPE, 32'h100, 32'd0, 5'd8);
        @(negedge clk);
        @(negedge clk);
        chk("fw_ren_wait", {31'd0, d_ren[1]}, 32'd1);
        flush[1] = 1'b1;
        @(posedge clk);
        #1 flush[1] = 1'b0;
        @(negedge clk);
        chk("fw_ren_drop", {31'd0, d_ren[1]}, 32'd0);
        chk("fw_ready", {31'd0, req_ready[1]}, 32'd1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | rsp_valid[1];
        end
        chk("fw_no_rsp", {31'd0, seen}, 32'd0);

        txn(0, SW_TYPE, 32'h200, 32'h55667788, 5'd0, lat, d, e, il, r, wn, rn);
        send(0, SW_TYPE, 32'h200, 32'h99999999, 5'd0);
        @(negedge clk);
        chk("rm_wen_issue", {31'd0, d_wen[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_wen_async", {31'd0, d_wen[0]}, 32'd0);
        chk("rm_outputs",
            d_addr[0] | d_wdata[0] | rsp_rdata[0] | {29'd0, d_op[0]}
            | {28'd0, req_ready[0], rsp_valid[0], d_ren[0], rsp_err[0]},
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(0, LW_TYPE, 32'h200, 32'd0, 5'd3, lat, d, e, il, r, wn, rn);
        chk("rm_old_value", d, 32'h55667788);

        chk("never_both_strobes", {31'd0, both_seen}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
